// File: rtl/approx_mac_pkg.sv
// rtl/approx_mac_pkg.sv - shared types and saturating-add helper for the approximate MAC path
package approx_mac_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

  // Operands arrive sign-extended to 32 bits; w is the saturation width. Returns {sum, clamp}.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic signed [32:0] s;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    s     = $signed({a[31], a}) + $signed({b[31], b});
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (w - 1));
    if (s > max_v) begin
      sat_add = {max_v[31:0], 1'b1};
    end else if (s < min_v) begin
      sat_add = {min_v[31:0], 1'b1};
    end else begin
      sat_add = {s[31:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational ACC_W-bit saturating adder
module sat_adder
  import approx_mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             clamp_o
);

  // The clamped sum always fits ACC_W bits, so the low ACC_W+1 bits carry {sum, clamp}.
  assign {sum_o, clamp_o} = (ACC_W + 1)'(sat_add(32'($signed(a_i)), 32'($signed(b_i)), ACC_W));

endmodule

// File: rtl/approx_dot_accumulator.sv
// rtl/approx_dot_accumulator.sv - streaming saturating dot-product accumulator with valid/ready result
module approx_dot_accumulator
  import approx_mac_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             osat_q, osat_d;

  logic             accept;
  logic             fresh;
  logic             closes;
  logic             clamp;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic [CNT_W-1:0] cnt_inc;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Any beat accepted outside ACCUM opens a new vector: add to zero, restart count and flag.
  assign fresh     = (state_q != ACCUM);
  assign add_a     = fresh ? '0 : acc_q;
  assign cnt_inc   = fresh ? CNT_ONE : cnt_q + CNT_ONE;
  assign closes    = in_last || (cnt_inc == CNT_MAX);
  assign prod_ext  = ACC_W'($signed(in_prod));

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .a_i     (add_a),
    .b_i     (prod_ext),
    .sum_o   (add_sum),
    .clamp_o (clamp)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    count_d = count_q;
    osat_d  = osat_q;
    if (accept) begin
      acc_d = add_sum;
      cnt_d = cnt_inc;
      sat_d = (fresh ? 1'b0 : sat_q) | clamp;
      if (closes) begin
        state_d = HOLD;
        sum_d   = add_sum;
        count_d = cnt_inc;
        osat_d  = sat_d;
      end else begin
        state_d = ACCUM;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      osat_q  <= osat_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_sat   = osat_q;

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// tb/tb_approx_dot_accumulator.sv - self-checking bench for approx_dot_accumulator (ACC_W=17, MAX_LEN=4)
module tb_approx_dot_accumulator;

  localparam int ACC_W   = 17;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;
  localparam int SMAX    = 65535;
  localparam int SMIN    = -65536;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int sum;
    int cnt;
    bit sat;
  } res_t;

  res_t exp_q[$];
  bit   m_open;
  int   m_acc;
  int   m_cnt;
  bit   m_sat;

  approx_dot_accumulator #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Reference: vector sum as plain integers, clamped after every add.
  function automatic void model_accept(input int prod, input bit last);
    int s;
    if (!m_open) begin
      m_acc = 0;
      m_cnt = 0;
      m_sat = 1'b0;
    end
    s = m_acc + prod;
    if (s > SMAX) begin
      s = SMAX;
      m_sat = 1'b1;
    end else if (s < SMIN) begin
      s = SMIN;
      m_sat = 1'b1;
    end
    m_acc = s;
    m_cnt = m_cnt + 1;
    if (last || m_cnt == MAX_LEN) begin
      exp_q.push_back('{m_acc, m_cnt, m_sat});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endfunction

  task automatic cycle(input bit v, input logic [15:0] p, input bit l, input bit r);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycle(0, 16'd0, 0, 0);
    cycle(0, 16'd0, 0, 0);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_during_rst got=%b exp=1", in_ready); end
    rst = 1'b0;
    cycle(0, 16'd0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_sum !== 17'd0) begin n_fail++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    cycle(1, 16'd100, 0, 1);
    cycle(1, -16'sd30, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    cycle(1, 16'd7, 1, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_sum !== 17'd77) begin n_fail++; $display("FAIL basic_sum got=%0d exp=77", $signed(out_sum)); end
    n_cmp++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", out_count); end
    n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
    cycle(0, 16'd0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_pos_saturation;
    cycle(1, 16'd32767, 0, 1);
    cycle(1, 16'd32767, 0, 1);
    cycle(1, 16'd32767, 1, 1);
    n_cmp++; if (out_sum !== 17'd65535) begin n_fail++; $display("FAIL possat_sum got=%0d exp=65535", $signed(out_sum)); end
    n_cmp++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL possat_flag got=%b exp=1", out_sat); end
    cycle(1, -16'sd5, 1, 1);
    n_cmp++; if (out_sum !== 17'(-5)) begin n_fail++; $display("FAIL possat_next_sum got=%0d exp=-5", $signed(out_sum)); end
    n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL possat_next_flag got=%b exp=0", out_sat); end
    n_cmp++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL possat_next_count got=%0d exp=1", out_count); end
    cycle(0, 16'd0, 0, 1);
  endtask

  task automatic test_forced_close;
    for (int i = 0; i < 4; i++) cycle(1, 16'd1, 0, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL forced_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_sum !== 17'd4) begin n_fail++; $display("FAIL forced_sum got=%0d exp=4", $signed(out_sum)); end
    n_cmp++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL forced_count got=%0d exp=4", out_count); end
    cycle(1, 16'd1, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL forced_reopen_valid got=%b exp=0", out_valid); end
    cycle(1, 16'd2, 1, 1);
    n_cmp++; if (out_sum !== 17'd3) begin n_fail++; $display("FAIL forced_second_sum got=%0d exp=3", $signed(out_sum)); end
    n_cmp++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL forced_second_count got=%0d exp=2", out_count); end
    cycle(0, 16'd0, 0, 1);
  endtask

  task automatic test_backpressure;
    cycle(1, 16'd10, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 16'd20, 1, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (out_sum !== 17'd10 || out_count !== 3'd1) begin
        n_fail++; $display("FAIL bp_stable[%0d] got=%0d/%0d exp=10/1", i, $signed(out_sum), out_count);
      end
    end
    cycle(1, 16'd20, 1, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_accept_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_sum !== 17'd20 || out_count !== 3'd1) begin
      n_fail++; $display("FAIL bp_drain_accept got=%0d/%0d exp=20/1", $signed(out_sum), out_count);
    end
    cycle(0, 16'd0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_final_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    cycle(1, -16'sd128, 1, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 17'(-128) || out_count !== 3'd1) begin
      n_fail++; $display("FAIL b2b_0 got=%b/%0d/%0d exp=1/-128/1", out_valid, $signed(out_sum), out_count);
    end
    cycle(1, 16'd127, 1, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 17'd127 || out_count !== 3'd1) begin
      n_fail++; $display("FAIL b2b_1 got=%b/%0d/%0d exp=1/127/1", out_valid, $signed(out_sum), out_count);
    end
    cycle(1, 16'd0, 1, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 17'd0 || out_count !== 3'd1) begin
      n_fail++; $display("FAIL b2b_2 got=%b/%0d/%0d exp=1/0/1", out_valid, $signed(out_sum), out_count);
    end
    cycle(0, 16'd0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    cycle(1, 16'd50, 0, 1);
    cycle(1, 16'd60, 0, 1);
    rst = 1'b1;
    cycle(0, 16'd0, 0, 1);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    cycle(1, 16'd5, 1, 1);
    n_cmp++; if (out_sum !== 17'd5) begin n_fail++; $display("FAIL rstmid_sum got=%0d exp=5", $signed(out_sum)); end
    n_cmp++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=1", out_count); end
    cycle(1, 16'd9, 1, 0);
    rst = 1'b1;
    cycle(0, 16'd0, 0, 0);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_sum !== 17'd0) begin
      n_fail++; $display("FAIL rsthold_discard got=%b/%0d exp=0/0", out_valid, $signed(out_sum));
    end
    cycle(0, 16'd0, 0, 1);
  endtask

  task automatic test_random;
    res_t r;
    m_open = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2004; i++) begin
      if (i < 2000) begin
        in_valid  = ($urandom_range(9) < 7);
        in_prod   = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(40) - 20);
        in_last   = ($urandom_range(3) == 0);
        out_ready = ($urandom_range(9) < 7);
      end else begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", i, in_ready, !out_valid || out_ready);
      end
      n_cmp++; if (out_valid !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, exp_q.size() != 0);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        r = exp_q.pop_front();
        n_cmp++; if (out_sum !== 17'(r.sum) || out_count !== 3'(r.cnt) || out_sat !== r.sat) begin
          n_fail++;
          $display("FAIL rand_result[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b", i, $signed(out_sum), out_count, out_sat, r.sum, r.cnt, r.sat);
        end
      end
      if (in_valid && in_ready) model_accept(int'($signed(in_prod)), in_last);
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = 16'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_pos_saturation();
    test_forced_close();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
